// File: rtl/pe_pkg.sv
// Shared definitions for the weight-stationary processing element.
//   - Mode encodings seen on the pe_ws_multi mode port.
//   - Internal state type and a mode-to-state decoder.
//   - Operand extension helper, used by the MAC datapath.
//     It works on words up to 64 bits wide.
package pe_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_WL   = 2'b01;
  localparam logic [1:0] MODE_PS   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WL   = 2'b01,
    ST_PS   = 2'b10
  } pe_state_e;

  // The reserved encoding 11 behaves as IDLE.
  function automatic pe_state_e mode_to_state(input logic [1:0] mode);
    case (mode)
      MODE_WL: return ST_WL;
      MODE_PS: return ST_PS;
      default: return ST_IDLE;
    endcase
  endfunction

  // Sign- or zero-extend the low src_w bits of val to 64 bits.
  function automatic logic [63:0] ext_operand(input logic [63:0] val,
                                              input int          src_w,
                                              input logic        is_signed);
    logic [63:0] keep_mask;
    logic        sign_bit;
    keep_mask = ~(~64'd0 << src_w);
    sign_bit  = |(val & (64'd1 << (src_w - 1)));
    if (is_signed && sign_bit) begin
      return val | ~keep_mask;
    end else begin
      return val & keep_mask;
    end
  endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// Combinational extend-multiply-add for one PE.
// Both operands are extended to ACC_W before the multiply.
// The extension is signed when SIGNED != 0 and unsigned otherwise.
// Result is ps_in + w * a.
// Without PE_SAT_EN the result wraps modulo 2^ACC_W.
// With PE_SAT_EN it clamps, and sat reports that a clamp happened.
// Ports:
//   w, a   : DATA_W operands (weight, activation)
//   ps_in  : ACC_W incoming partial sum
//   sum    : ACC_W result
//   sat    : clamp indicator (only when PE_SAT_EN is defined)
module pe_mac_unit
  import pe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] a,
  input  logic [ACC_W-1:0]  ps_in,
`ifdef PE_SAT_EN
  output logic              sat,
`endif
  output logic [ACC_W-1:0]  sum
);

  logic [ACC_W-1:0] w_acc_s;
  logic [ACC_W-1:0] a_acc_s;
  logic [ACC_W-1:0] prod_s;

  // ACC_W >= 2*DATA_W, so the product of extended operands never loses information
  assign w_acc_s = ACC_W'(ext_operand(64'(w), DATA_W, SIGNED != 0));
  assign a_acc_s = ACC_W'(ext_operand(64'(a), DATA_W, SIGNED != 0));
  assign prod_s  = w_acc_s * a_acc_s;

`ifdef PE_SAT_EN
  logic [ACC_W:0] sum_wide_s;
  assign sum_wide_s = {1'b0, ps_in} + {1'b0, prod_s};

  // Clamp on overflow: operand/result signs when signed, carry-out when unsigned
  always_comb begin
    sum = sum_wide_s[ACC_W-1:0];
    sat = 1'b0;
    if (SIGNED != 0) begin
      if ((ps_in[ACC_W-1] == prod_s[ACC_W-1]) &&
          (sum_wide_s[ACC_W-1] != ps_in[ACC_W-1])) begin
        sat = 1'b1;
        sum = ps_in[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        sum = sum_wide_s[ACC_W-1:0];
      end
    end else begin
      if (sum_wide_s[ACC_W]) begin
        sat = 1'b1;
        sum = {ACC_W{1'b1}};
      end else begin
        sum = sum_wide_s[ACC_W-1:0];
      end
    end
  end
`else
  assign sum = ps_in + prod_s;
`endif

endmodule

// File: rtl/pe_ws_multi.sv
// Weight-stationary PE that holds W_DEPTH weights.
//
// Weight loading (mode WLOAD):
//   - Weights arrive on a daisy-chained weight bus.
//   - The first W_DEPTH valid words fill the local bank.
//   - Later words are forwarded to the next PE.
//
// Compute (mode COMPUTE):
//   - Each valid activation computes ps_in + bank[w_sel_in] * a_in.
//   - It forwards the activation and the select, with one cycle of latency.
//
// Optional macro PE_SAT_EN:
//   - The accumulate saturates instead of wrapping.
//   - A sat_flag output port is added.
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   mode                       : 00 IDLE, 01 WLOAD, 10 COMPUTE, 11 as IDLE
//   w_valid_in, w_in           : incoming weight bus
//   w_valid_out, w_out         : forwarded weight bus
//   load_done                  : all slots filled since entering WLOAD
//   a_valid_in, a_in, w_sel_in : activation, slot select
//   ps_in                      : partial sum in
//   a_valid_out, a_out,
//   w_sel_out, ps_out          : registered results
//   sat_flag                   : clamp indicator (PE_SAT_EN only)
module pe_ws_multi
  import pe_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int ACC_W   = 32,
  parameter  int W_DEPTH = 4,
  parameter  int SIGNED  = 1,
  localparam int SEL_W   = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              w_valid_in,
  input  logic [DATA_W-1:0] w_in,
  output logic              w_valid_out,
  output logic [DATA_W-1:0] w_out,
  output logic              load_done,
  input  logic              a_valid_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [SEL_W-1:0]  w_sel_in,
  input  logic [ACC_W-1:0]  ps_in,
  output logic              a_valid_out,
  output logic [DATA_W-1:0] a_out,
  output logic [SEL_W-1:0]  w_sel_out,
`ifdef PE_SAT_EN
  output logic              sat_flag,
`endif
  output logic [ACC_W-1:0]  ps_out
);

  localparam int               CNT_W   = $clog2(W_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(W_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

  pe_state_e         st_r;
  pe_state_e         st_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_base_s;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              wr_en_s;
  logic              fwd_en_s;
  logic              a_fire_s;
  logic [DATA_W-1:0] bank_r [W_DEPTH];
  logic [DATA_W-1:0] w_pick_s;
  logic [ACC_W-1:0]  mac_sum_s;
`ifdef PE_SAT_EN
  logic              mac_sat_s;
`endif

  // Mode decode and the fill-then-forward decision for this cycle's weight word
  always_comb begin
    st_next_s  = mode_to_state(mode);
    cnt_base_s = cnt_r;
    cnt_next_s = cnt_r;
    wr_en_s    = 1'b0;
    fwd_en_s   = 1'b0;
    if (st_next_s == ST_WL) begin
      // On WLOAD entry the counter restarts, so a same-cycle word lands in slot 0
      if (st_r != ST_WL) begin
        cnt_base_s = {CNT_W{1'b0}};
      end else begin
        cnt_base_s = cnt_r;
      end
      if (w_valid_in) begin
        if (cnt_base_s < DEPTH_C) begin
          wr_en_s    = 1'b1;
          cnt_next_s = cnt_base_s + CNT_ONE;
        end else begin
          fwd_en_s   = 1'b1;
          cnt_next_s = cnt_base_s;
        end
      end else begin
        cnt_next_s = cnt_base_s;
      end
    end else begin
      cnt_next_s = cnt_r;
    end
    a_fire_s = (st_next_s == ST_PS) && a_valid_in;
  end

  // Slot read; selects beyond W_DEPTH match no slot and yield weight 0
  always_comb begin
    w_pick_s = {DATA_W{1'b0}};
    for (int i = 0; i < W_DEPTH; i++) begin
      w_pick_s = (w_sel_in == SEL_W'(i)) ? bank_r[i] : w_pick_s;
    end
  end

  pe_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .w     (w_pick_s),
    .a     (a_in),
    .ps_in (ps_in),
`ifdef PE_SAT_EN
    .sat   (mac_sat_s),
`endif
    .sum   (mac_sum_s)
  );

  // Weight bank storage, written only while filling in WLOAD
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < W_DEPTH; i++) begin
        bank_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < W_DEPTH; i++) begin
        if (wr_en_s && (cnt_base_s == CNT_W'(i))) begin
          bank_r[i] <= w_in;
        end
      end
    end
  end

  // State, fill counter and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      st_r        <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      load_done   <= 1'b0;
      w_valid_out <= 1'b0;
      w_out       <= {DATA_W{1'b0}};
      a_valid_out <= 1'b0;
      a_out       <= {DATA_W{1'b0}};
      w_sel_out   <= {SEL_W{1'b0}};
      ps_out      <= {ACC_W{1'b0}};
`ifdef PE_SAT_EN
      sat_flag    <= 1'b0;
`endif
    end else begin
      st_r        <= st_next_s;
      cnt_r       <= cnt_next_s;
      load_done   <= (cnt_next_s == DEPTH_C);
      w_valid_out <= fwd_en_s;
      if (fwd_en_s) begin
        w_out <= w_in;
      end
      a_valid_out <= a_fire_s;
      if (a_fire_s) begin
        a_out     <= a_in;
        w_sel_out <= w_sel_in;
        ps_out    <= mac_sum_s;
`ifdef PE_SAT_EN
        sat_flag  <= mac_sat_s;
`endif
      end
    end
  end

endmodule
